// File: rtl/fma_dot_seq_if.sv
// Stream and datapath bundle for fma_dot_seq: control, operand stream,
// FMA operand/result lines and the result stream.
interface fma_dot_seq_if #(
  parameter int LEN_W = 8
);
  // Chain control
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      init_acc;
  logic             abort;
  logic             busy;

  // Operand stream (bf16 pairs)
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;

  // Shared FMA datapath
  logic [15:0]      fma_a;
  logic [15:0]      fma_b;
  logic [31:0]      fma_c;
  logic [31:0]      fma_out;

  // Result stream (fp32)
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;

  // The surrounding system: operand fetch, FMA instance and result consumer
  modport master (
    output start, len, init_acc, abort,
    output op_valid, op_a, op_b,
    output fma_out,
    output res_ready,
    input  busy, op_ready, fma_a, fma_b, fma_c, res_valid, res_data
  );

  // The sequencer
  modport slave (
    input  start, len, init_acc, abort,
    input  op_valid, op_a, op_b,
    input  fma_out,
    input  res_ready,
    output busy, op_ready, fma_a, fma_b, fma_c, res_valid, res_data
  );
endinterface

// File: rtl/fma_dot_seq.sv
// Dot-product / accumulate-chain sequencer for an external bf16 x bf16 + fp32
// FMA. Issues one operand pair at a time, waits the FMA latency, writes the
// result back into the accumulator and returns the final value on a
// valid/ready result port. FMA_LAT must be at least 1.
module fma_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int FMA_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  fma_dot_seq_if.slave  bus
);

  // Wait counter only has to hold FMA_LAT-1; keep it at least one bit wide.
  localparam int WCNT_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(FMA_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        acc_q,   acc_d;
  logic [LEN_W-1:0]   rem_q,   rem_d;
  logic [WCNT_W-1:0]  wcnt_q,  wcnt_d;
  logic [15:0]        fma_a_q, fma_a_d;
  logic [15:0]        fma_b_q, fma_b_d;
  logic [31:0]        fma_c_q, fma_c_d;

  // Next-state and datapath update for the chain sequencer
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    fma_a_d = fma_a_q;
    fma_b_d = fma_b_q;
    fma_c_d = fma_c_q;

    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here; start alone decides
        if (bus.start) begin
          acc_d   = bus.init_acc;
          rem_d   = bus.len;
          state_d = (bus.len != '0) ? S_LOAD : S_DONE;
        end
      end

      S_LOAD: begin
        if (bus.abort) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (bus.op_valid) begin
          fma_a_d = bus.op_a;
          fma_b_d = bus.op_b;
          fma_c_d = acc_q;
          wcnt_d  = WCNT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // abort suppresses the write-back that would land on this edge
        if (bus.abort) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          acc_d   = bus.fma_out;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_DONE : S_LOAD;
        end
      end

      S_DONE: begin
        // start is not looked at here, so it cannot race the handshake
        if (bus.abort) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset discards any chain
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      fma_a_q <= '0;
      fma_b_q <= '0;
      fma_c_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      fma_a_q <= fma_a_d;
      fma_b_q <= fma_b_d;
      fma_c_q <= fma_c_d;
    end
  end

  // Handshake outputs depend on state only: no path from op_valid/res_ready
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.op_ready  = (state_q == S_LOAD);
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.res_data  = acc_q;
  assign bus.fma_a     = fma_a_q;
  assign bus.fma_b     = fma_b_q;
  assign bus.fma_c     = fma_c_q;

endmodule

// File: doc/fma_dot_seq.md
# fma_dot_seq

Sequencer that drives the shared bf16×bf16+fp32 fused multiply-add datapath to compute a dot product / accumulate chain. It accepts a length and an initial fp32 accumulator and consumes `len` operand pairs over a valid/ready stream. For each pair it presents `{a, b, acc}` to the FMA, waits the FMA's fixed latency and writes the result back into the accumulator. When the chain ends it presents the final fp32 result on a valid/ready result port. It sits between the operand fetch logic and the FMA instance; the FMA itself stays outside this block.

## Interface
- `LEN_W`, 8: width of the element-count field.
- `FMA_LAT`, 1: cycles from registered FMA operands to a sampleable `fma_out`; must be ≥1.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a chain; honored only in IDLE.
- `len` in LEN_W: number of operand pairs, sampled with `start`.
- `init_acc` in 32: initial fp32 accumulator, sampled with `start`.
- `abort` in 1: synchronous cancel of the current chain.
- `busy` out 1: high in any state other than IDLE.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: high only in LOAD.
- `op_a`, `op_b` in 16 each: bf16 operands.
- `fma_a`, `fma_b` out 16 each: registered operands to the FMA.
- `fma_c` out 32: registered addend to the FMA, which is the accumulator.
- `fma_out` in 32: FMA result.
- `res_valid` out 1: final result available.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 32: final accumulator.

## Operation
- States: IDLE, LOAD, WAIT, DONE.
- **IDLE**
  - On `start`: acc←`init_acc`, rem←`len`.
  - Next state is LOAD if `len`≠0, otherwise DONE.
- **LOAD**
  - `op_ready`=1.
  - On `op_valid`: `fma_a`←`op_a`, `fma_b`←`op_b`, `fma_c`←acc, wcnt←FMA_LAT−1; go to WAIT.
  - Without `op_valid`: hold in LOAD indefinitely.
- **WAIT**
  - While wcnt≠0: decrement wcnt.
  - When wcnt=0: acc←`fma_out`, rem←rem−1.
  - Next state is DONE if rem was 1, otherwise LOAD.
- **DONE**
  - `res_valid`=1, `res_data`=acc.
  - On `res_ready`: go to IDLE.
- **Abort**
  - `abort` in any non-IDLE state: go to IDLE next cycle and clear acc to 0.
  - `res_valid` is never raised for an aborted chain.
  - `abort` beats `op_valid`, `res_ready` and a WAIT write-back in the same cycle; no operand is consumed and acc is not updated.
  - `abort` in IDLE is ignored; if `start` is also high in IDLE, `start` wins.
- **Boundaries**
  - `start` while busy is ignored, and `len`/`init_acc` are not resampled.
  - `start` in the same cycle as the DONE→IDLE handshake is ignored; `start` is accepted from IDLE only.
  - `len`=0 returns `init_acc` unchanged and issues no FMA operation.
  - `len`=2^LEN_W−1 runs the full count; rem never wraps.
  - `op_a`/`op_b` are not inspected. NaN, Inf and sign are passed straight to the FMA.
- **Reset values**
  - State IDLE.
  - `busy`, `op_ready`, `res_valid` are 0.
  - `fma_a`, `fma_b`, `fma_c`, `res_data`, acc, rem, wcnt are 0.
  - Reset mid-chain discards all progress.

## Timing
- `start` at edge t (IDLE, `len`≠0): `busy`=1 and `op_ready`=1 from t+1.
- Operand handshake at edge t:
  - `fma_*` registers are valid from t+1.
  - `fma_out` is sampled at edge t+FMA_LAT.
  - `op_ready` is high again from t+FMA_LAT+1.
- Throughput is one element per FMA_LAT+1 cycles when `op_valid` is held high.
- Chain latency with continuous operands: `start` to `res_valid` = 1 + len·(FMA_LAT+1) cycles.
- `start` with `len`=0: `res_valid` at t+1.
- `res_valid` and `res_data` are held stable until `res_ready`. After the handshake, `res_valid`=0 and `busy`=0 the next cycle.
- `op_ready` and `res_valid` are pure functions of state; there are no combinational paths from `op_valid` or `res_ready`.

## Test plan
Every scenario except the last uses a bench FMA stub with `fma_out` = `fma_c` + `{16'h0, fma_a}`, registered (FMA_LAT=1).

- `len`=3, `init_acc`=0x00000010, `op_a`=1,2,3 back-to-back -> `res_data`=0x00000016, `res_valid` 7 cycles after `start`, and each `fma_c` equals the previous write-back.
- `len`=0, `init_acc`=0x3F800000 -> `res_valid` one cycle after `start`, `res_data`=0x3F800000, `op_ready` never asserted.
- `len`=2 with `op_valid` gapped 5 cycles between pairs and `res_ready` held low 4 cycles -> `op_ready` holds; result 0x10+a0+a1 is held stable until `res_ready`; a second `start` during DONE is ignored.
- `abort` asserted in WAIT together with the write-back edge, on pair 2 of 4 -> state IDLE next cycle, `busy`=0, acc=0, no `res_valid`; a following `len`=1 chain completes correctly.
- `rst` pulsed asynchronously mid-LOAD -> all outputs 0 immediately, state IDLE; `start` after reset release runs normally.
- FMA_LAT=3 build, `len`=2 -> `op_ready` re-asserts 4 cycles after each handshake; `fma_out` is sampled only at the third post-issue edge, checked with a stub output that is garbage for the first 2 cycles.
